// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: capture PI, shift WIDTH bits from SI out of SO, latch chain to PO, pulse DONE.
// START to DONE is WIDTH+3 cycles; START is ignored while BUSY, and ABORT drops back to IDLE without DONE.
module scan_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] PI,
  input  logic             SI,
  output logic             SE,
  output logic             SO,
  output logic [WIDTH-1:0] PO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] chain;
  logic [CNT_W-1:0] cnt;

  // Outputs are registered alongside the state they belong to, so SO/SE/BUSY/DONE
  // always reflect the state being entered and never see the inputs combinationally.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state <= IDLE;
      chain <= '0;
      cnt   <= '0;
      PO    <= '0;
      SE    <= 1'b0;
      SO    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else if (ABORT && (state == CAPTURE || state == SHIFT || state == UPDATE)) begin
      state <= IDLE;
      SE    <= 1'b0;
      SO    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state <= CAPTURE;
            BUSY  <= 1'b1;
          end
        end
        CAPTURE: begin
          chain <= PI;
          cnt   <= '0;
          state <= SHIFT;
          SE    <= 1'b1;
          SO    <= PI[WIDTH-1];
        end
        SHIFT: begin
          chain <= {chain[WIDTH-2:0], SI};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= UPDATE;
            SE    <= 1'b0;
            SO    <= 1'b0;
          end else begin
            // next MSB after this shift
            SO <= chain[WIDTH-2];
          end
        end
        UPDATE: begin
          PO    <= chain;
          state <= FIN;
          DONE  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          SE    <= 1'b0;
          SO    <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl (WIDTH=8): inputs driven and outputs sampled on the falling edge.
module tb_scan_chain_ctrl;

  logic       CLK;
  logic       R;
  logic       START;
  logic       ABORT;
  logic [7:0] PI;
  logic       SI;
  logic       SE;
  logic       SO;
  logic [7:0] PO;
  logic       BUSY;
  logic       DONE;

  int tests;
  int failed;

  scan_chain_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
    .CLK  (CLK),
    .R    (R),
    .START(START),
    .ABORT(ABORT),
    .PI   (PI),
    .SI   (SI),
    .SE   (SE),
    .SO   (SO),
    .PO   (PO),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    R = 1'b0; START = 1'b0; ABORT = 1'b0; PI = 8'h00; SI = 1'b0;
    #2;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0000) begin
      failed++; $display("FAIL reset_flags: got %b want 0000", {SE, SO, BUSY, DONE});
    end
    tests++;
    if (PO !== 8'h00) begin
      failed++; $display("FAIL reset_po: got %h want 00", PO);
    end
    // release and request on the same falling edge: first rising edge must take START
    @(negedge CLK);
    R = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    tests++;
    if ({SE, BUSY} !== 2'b01) begin
      failed++; $display("FAIL reset_first_start: got SE,BUSY=%b want 01", {SE, BUSY});
    end
    for (int i = 0; i < 20 && BUSY; i++) @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin
      failed++; $display("FAIL reset_drain: BUSY=%b want 0", BUSY);
    end
  endtask

  task automatic test_shift_in();
    logic [7:0]  bits;
    logic [12:0] busy_v;
    logic [12:0] done_v;
    bits = 8'b1100_1011;
    PI = 8'h00; SI = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
      busy_v[c-1] = BUSY;
      done_v[c-1] = DONE;
      if (c >= 2 && c <= 9) begin
        tests++;
        if (SO !== 1'b0) begin
          failed++; $display("FAIL shift_in_so[%0d]: got %b want 0", c - 2, SO);
        end
        SI = bits[9-c];
      end else begin
        SI = 1'b0;
      end
    end
    tests++;
    if (busy_v !== 13'h07FF) begin
      failed++; $display("FAIL shift_in_busy: got %b want %b", busy_v, 13'h07FF);
    end
    tests++;
    if (done_v !== 13'h0400) begin
      failed++; $display("FAIL shift_in_done: got %b want %b", done_v, 13'h0400);
    end
    tests++;
    if (PO !== 8'hCB) begin
      failed++; $display("FAIL shift_in_po: got %h want cb", PO);
    end
  endtask

  task automatic test_capture_shift();
    logic [7:0] pat;
    pat = 8'hA5;
    PI = pat; SI = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0010) begin
      failed++; $display("FAIL capture_flags: got %b want 0010", {SE, SO, BUSY, DONE});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      tests++;
      if ({SE, SO, BUSY, DONE} !== {1'b1, pat[7-i], 2'b10}) begin
        failed++;
        $display("FAIL shift_flags[%0d]: got %b want %b", i, {SE, SO, BUSY, DONE}, {1'b1, pat[7-i], 2'b10});
      end
    end
    @(negedge CLK);
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0010 || PO !== 8'hCB) begin
      failed++; $display("FAIL update_cycle: got flags %b po %h want 0010 cb", {SE, SO, BUSY, DONE}, PO);
    end
    @(negedge CLK);
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0011) begin
      failed++; $display("FAIL fin_flags: got %b want 0011", {SE, SO, BUSY, DONE});
    end
    tests++;
    if (PO !== 8'h00) begin
      failed++; $display("FAIL capture_po: got %h want 00", PO);
    end
    @(negedge CLK);
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0000) begin
      failed++; $display("FAIL idle_after_fin: got %b want 0000", {SE, SO, BUSY, DONE});
    end
  endtask

  task automatic test_abort_shift();
    logic [7:0] bits;
    logic       bad;
    bits = 8'h3C;
    PI = 8'hFF; SI = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
      SI = (c >= 2 && c <= 9) ? bits[9-c] : 1'b0;
    end
    tests++;
    if (PO !== 8'h3C) begin
      failed++; $display("FAIL abort_setup_po: got %h want 3c", PO);
    end
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
    end
    tests++;
    if (SE !== 1'b1) begin
      failed++; $display("FAIL abort_in_shift: SE=%b want 1", SE);
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0000) begin
      failed++; $display("FAIL abort_flags: got %b want 0000", {SE, SO, BUSY, DONE});
    end
    tests++;
    if (PO !== 8'h3C) begin
      failed++; $display("FAIL abort_po: got %h want 3c", PO);
    end
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      failed++; $display("FAIL abort_quiet: DONE/BUSY seen after abort, got %b want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int first_done;
    int second_done;
    int idle_cnt;
    done_cnt = 0; first_done = -1; second_done = -1; idle_cnt = 0;
    PI = 8'h5A; SI = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (BUSY !== 1'b1) idle_cnt++;
    end
    START = 1'b0;
    tests++;
    if (done_cnt !== 2 || first_done !== 11) begin
      failed++; $display("FAIL b2b_first_done: got count %0d at %0d want 2 at 11", done_cnt, first_done);
    end
    tests++;
    if (second_done - first_done !== 12) begin
      failed++; $display("FAIL b2b_spacing: got %0d want 12", second_done - first_done);
    end
    tests++;
    if (idle_cnt !== 2) begin
      failed++; $display("FAIL b2b_idle_cycles: got %0d want 2", idle_cnt);
    end
    for (int i = 0; i < 20 && BUSY; i++) @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin
      failed++; $display("FAIL b2b_drain: BUSY=%b want 0", BUSY);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0]  bits;
    logic [12:0] done_v;
    int          se_cnt;
    PI = 8'hFF; SI = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
    end
    tests++;
    if ({SE, SO} !== 2'b11) begin
      failed++; $display("FAIL areset_pre: got SE,SO=%b want 11", {SE, SO});
    end
    #2 R = 1'b0;
    #1;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0000 || PO !== 8'h00) begin
      failed++; $display("FAIL areset_now: got flags %b po %h want 0000 00", {SE, SO, BUSY, DONE}, PO);
    end
    @(negedge CLK);
    R = 1'b1;
    bits = 8'h55; PI = 8'h81; se_cnt = 0;
    @(negedge CLK);
    START = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
      done_v[c-1] = DONE;
      if (SE === 1'b1) se_cnt++;
      SI = (c >= 2 && c <= 9) ? bits[9-c] : 1'b0;
    end
    tests++;
    if (se_cnt !== 8) begin
      failed++; $display("FAIL areset_shift_len: got %0d want 8", se_cnt);
    end
    tests++;
    if (done_v !== 13'h0400) begin
      failed++; $display("FAIL areset_done: got %b want %b", done_v, 13'h0400);
    end
    tests++;
    if (PO !== 8'h55) begin
      failed++; $display("FAIL areset_po: got %h want 55", PO);
    end
  endtask

  task automatic test_start_abort_idle();
    PI = 8'hFF; SI = 1'b1;
    @(negedge CLK);
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0010) begin
      failed++; $display("FAIL start_wins_capture: got %b want 0010", {SE, SO, BUSY, DONE});
    end
    @(negedge CLK);
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b1110) begin
      failed++; $display("FAIL start_wins_shift: got %b want 1110", {SE, SO, BUSY, DONE});
    end
    for (int c = 3; c <= 10; c++) @(negedge CLK);
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0010) begin
      failed++; $display("FAIL update_before_abort: got %b want 0010", {SE, SO, BUSY, DONE});
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    tests++;
    if ({SE, SO, BUSY, DONE} !== 4'b0000) begin
      failed++; $display("FAIL update_abort_flags: got %b want 0000", {SE, SO, BUSY, DONE});
    end
    tests++;
    if (PO !== 8'h55) begin
      failed++; $display("FAIL update_abort_po: got %h want 55", PO);
    end
    @(negedge CLK);
    tests++;
    if (DONE !== 1'b0) begin
      failed++; $display("FAIL update_abort_done: got %b want 0", DONE);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_shift_in();
    test_capture_shift();
    test_abort_shift();
    test_back_to_back();
    test_async_reset();
    test_start_abort_idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
